// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - per-channel synchronize, debounce, edge-detect and auto-repeat
// Every internal value is active-high; INVERT_MASK is applied ahead of the synchronizer.
module input_conditioner #(
   parameter int            N               = 4,
   parameter int            DEBOUNCE_CYCLES = 270000,
   parameter int            REPEAT_DELAY    = 13500000,
   parameter int            REPEAT_PERIOD   = 2700000,
   parameter logic [N-1:0]  INVERT_MASK     = '0,
   parameter logic [N-1:0]  REPEAT_MASK     = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] raw_in,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] release_pulse,
   output logic [N-1:0] strobe
);

   localparam int CW    = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam int TMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   for (genvar i = 0; i < N; i++) begin : g_ch
      logic          s1_q, s1_d;
      logic          s2_q, s2_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
      logic          strobe_q, strobe_d;
      logic [1:0]    state_q, state_d;
      logic [TW-1:0] timer_q, timer_d;
      logic          repeat_hit;

      always_comb begin
         s1_d       = raw_in[i] ^ INVERT_MASK[i];
         s2_d       = s1_q;
         cnt_d      = cnt_q;
         level_d    = level_q;
         press_d    = 1'b0;
         release_d  = 1'b0;
         state_d    = state_q;
         timer_d    = timer_q;
         repeat_hit = 1'b0;

         // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
         if (s2_q == level_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            level_d   = s2_q;
            press_d   = s2_q;
            release_d = ~s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end

         // Release wins over a coincident repeat expiry.
         if (REPEAT_MASK[i]) begin
            if (release_d) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else begin
               case (state_q)
                  ST_IDLE: begin
                     if (press_d) begin
                        state_d = ST_HOLD;
                        timer_d = '0;
                     end
                  end
                  ST_HOLD: begin
                     if (timer_q == DELAY_LAST) begin
                        repeat_hit = 1'b1;
                        state_d    = ST_REPEAT;
                        timer_d    = '0;
                     end else begin
                        timer_d = timer_q + 1'b1;
                     end
                  end
                  ST_REPEAT: begin
                     if (timer_q == PERIOD_LAST) begin
                        repeat_hit = 1'b1;
                        timer_d    = '0;
                     end else begin
                        timer_d = timer_q + 1'b1;
                     end
                  end
                  default: begin
                     state_d = ST_IDLE;
                     timer_d = '0;
                  end
               endcase
            end
         end

         strobe_d = press_d | repeat_hit;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            strobe_q  <= 1'b0;
            state_q   <= ST_IDLE;
            timer_q   <= '0;
         end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            strobe_q  <= strobe_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
         end
      end

      assign level[i]         = level_q;
      assign press[i]         = press_q;
      assign release_pulse[i] = release_q;
      assign strobe[i]        = strobe_q;
   end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - randomized and directed checks against a behavioural model
module tb_input_conditioner;
   localparam int         N   = 2;
   localparam int         DEB = 4;
   localparam int         RD  = 10;
   localparam int         RP  = 3;
   localparam logic [1:0] INV = 2'b10;
   localparam logic [1:0] RM  = 2'b01;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] raw_in = 2'b10;
   logic [1:0] level, press, release_pulse, strobe;

   always #5 clk = ~clk;

   input_conditioner #(
      .N(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
      .INVERT_MASK(INV), .REPEAT_MASK(RM)
   ) dut (
      .clk(clk), .rst_n(rst_n), .raw_in(raw_in),
      .level(level), .press(press), .release_pulse(release_pulse), .strobe(strobe)
   );

   int checks = 0;
   int errors = 0;
   int ecount = 0;

   // model: pin samples history, run length of disagreement, and press time per channel
   logic [1:0] p1 = '0, p2 = '0, m_level = '0;
   logic [1:0] e_level = '0, e_press = '0, e_rel = '0, e_strobe = '0;
   int  run[2];
   bit  held[2];
   int  pedge[2];

   int  press_cnt[2];
   int  rel_cnt[2];
   int  strb_cnt[2];
   int  stq[$];

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %b expected %b", name, ecount, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      p1 = '0; p2 = '0; m_level = '0;
      e_level = '0; e_press = '0; e_rel = '0; e_strobe = '0;
      for (int c = 0; c < 2; c++) begin
         run[c] = 0; held[c] = 1'b0; pedge[c] = 0;
      end
   endtask

   always @(posedge clk) begin
      ecount++;
      if (!rst_n) begin
         model_reset();
      end else begin
         e_press = '0; e_rel = '0; e_strobe = '0;
         for (int c = 0; c < 2; c++) begin
            logic sync;
            int   age;
            sync  = p2[c];
            p2[c] = p1[c];
            p1[c] = raw_in[c] ^ INV[c];
            if (sync != m_level[c]) begin
               run[c]++;
               if (run[c] == DEB) begin
                  m_level[c] = sync;
                  run[c] = 0;
                  if (sync) e_press[c] = 1'b1;
                  else      e_rel[c]   = 1'b1;
               end
            end else begin
               run[c] = 0;
            end
            if (e_press[c]) begin
               held[c]  = 1'b1;
               pedge[c] = ecount;
            end
            if (e_rel[c]) held[c] = 1'b0;
            age = ecount - pedge[c];
            e_strobe[c] = e_press[c] |
                          (RM[c] && held[c] && age >= RD && ((age - RD) % RP) == 0);
         end
         e_level = m_level;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) model_reset();
      chk("level", level, e_level);
      chk("press", press, e_press);
      chk("release", release_pulse, e_rel);
      chk("strobe", strobe, e_strobe);
      for (int c = 0; c < 2; c++) begin
         if (press[c])         press_cnt[c]++;
         if (release_pulse[c]) rel_cnt[c]++;
         if (strobe[c])        strb_cnt[c]++;
      end
      if (strobe[0]) stq.push_back(ecount);
   end

   task automatic wait_press(input int ch, output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
         #1;
      end while (!press[ch] && n < 40);
   endtask

   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #3;
   endtask

   initial begin
      int n, p, qbase, b_p, b_r, b_s;
      int exp_off[4];
      int bounce[4];
      exp_off = '{0, 10, 13, 16};
      bounce  = '{1, 0, 1, 0};
      for (int c = 0; c < 2; c++) begin
         press_cnt[c] = 0; rel_cnt[c] = 0; strb_cnt[c] = 0;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("reset_level", level, 2'b00);
      chk("reset_strobe", strobe, 2'b00);
      #2 rst_n = 1'b1;
      idle(10);

      // clean press followed by auto-repeat
      raw_in[0] = 1'b1;
      wait_press(0, n);
      chk_int("press_latency", n, 6);
      p = ecount;
      qbase = stq.size() - 1;
      chk("press_level", level & 2'b01, 2'b01);
      @(negedge clk); #1;
      chk("press_width", press & 2'b01, 2'b00);
      chk("level_hold", level & 2'b01, 2'b01);
      repeat (17) @(posedge clk);
      @(negedge clk); #1;
      chk_int("repeat_count", (stq.size() - qbase >= 4) ? 4 : stq.size() - qbase, 4);
      for (int k = 0; k < 4; k++)
         if (qbase + k < stq.size()) chk_int("repeat_offset", stq[qbase + k] - p, exp_off[k]);
      @(posedge clk); #3;
      b_r = rel_cnt[0];
      raw_in[0] = 1'b0;
      idle(20);
      chk_int("release_once", rel_cnt[0] - b_r, 1);
      b_s = strb_cnt[0];
      idle(20);
      chk_int("no_strobe_after_release", strb_cnt[0] - b_s, 0);

      // release lands exactly on the P+16 repeat expiry
      raw_in[0] = 1'b1;
      wait_press(0, p);
      p = ecount;
      repeat (10) @(posedge clk);
      #3 raw_in[0] = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk); #1;
      chk_int("collision_edge", ecount - p, 16);
      chk("collision_release", release_pulse & 2'b01, 2'b01);
      chk("collision_strobe", strobe & 2'b01, 2'b00);
      idle(10);

      // bounce then settle high
      b_p = press_cnt[0]; b_r = rel_cnt[0];
      for (int k = 0; k < 4; k++) begin
         raw_in[0] = bounce[k][0];
         idle(2);
      end
      raw_in[0] = 1'b1;
      wait_press(0, n);
      chk_int("bounce_latency", n, 6);
      chk_int("bounce_presses", press_cnt[0] - b_p, 1);
      chk_int("bounce_releases", rel_cnt[0] - b_r, 0);
      @(posedge clk); #3 raw_in[0] = 1'b0;
      idle(20);

      // inverted channel, no repeat
      b_p = press_cnt[1]; b_s = strb_cnt[1];
      raw_in[1] = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk); #1;
      chk_int("inv_presses", press_cnt[1] - b_p, 1);
      chk_int("inv_strobes", strb_cnt[1] - b_s, 1);
      chk("inv_level", level & 2'b10, 2'b10);
      @(posedge clk); #3 raw_in[1] = 1'b1;
      idle(20);

      // asynchronous reset while in REPEAT
      raw_in[0] = 1'b1;
      wait_press(0, n);
      repeat (12) @(posedge clk);
      #2;
      chk("pre_reset_level", level & 2'b01, 2'b01);
      #1 rst_n = 1'b0;
      #1;
      chk("async_level", level, 2'b00);
      chk("async_press", press, 2'b00);
      chk("async_release", release_pulse, 2'b00);
      chk("async_strobe", strobe, 2'b00);
      @(posedge clk); #3 rst_n = 1'b1;
      wait_press(0, n);
      chk_int("post_reset_press", n, 6);
      @(posedge clk); #3 raw_in[0] = 1'b0;
      idle(20);

      // randomized pin activity with occasional resets
      repeat (300) begin
         idle($urandom_range(1, 30));
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            idle(1);
            rst_n = 1'b1;
         end
         raw_in = raw_in ^ 2'($urandom_range(0, 3));
      end
      idle(30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Conditions raw mechanical inputs (manual clock-step button, program button, reset button, etc.) before they reach the clock unit and the manual-program path. Each channel is synchronized, debounced and edge-detected. Optional auto-repeat turns a held button into a periodic strobe. The block sits directly upstream of the clock module's manual_toggle input and the MAR/RAM manual-read inputs, and replaces the raw gpio_button feed.

Parameters:
N, 4, number of independent input channels
DEBOUNCE_CYCLES, 270000, consecutive stable samples needed to accept a level change (10 ms @ 27 MHz); must be >= 1
REPEAT_DELAY, 13500000, cycles from press to first auto-repeat strobe (500 ms); must be >= 1
REPEAT_PERIOD, 2700000, cycles between later repeat strobes (100 ms); must be >= 1
INVERT_MASK, N'b0, bit i = 1 means channel i is active-low at the pin
REPEAT_MASK, N'b0, bit i = 1 enables auto-repeat on channel i

Ports:
clk  input  1  system clock (27 MHz board clock)
rst_n  input  1  asynchronous active-low reset
raw_in  input  N  unsynchronized pin levels
level  output  N  debounced level, 1 = pressed
press  output  N  1-cycle pulse on debounced press
release  output  N  1-cycle pulse on debounced release
strobe  output  N  1-cycle pulse: press, plus auto-repeat pulses where enabled

Behaviour:
- Reset: one clock only; rst_n is asynchronous and active-low. Asserting rst_n clears all synchronizer flops, counters and FSMs. level, press, release and strobe all read 0. State is "released" regardless of pin level.
- Polarity: raw_in XOR INVERT_MASK is taken before synchronization. Every internal value is active-high.
- Sync: 2-flop synchronizer per channel; s2 is the synchronized value.
- Debounce: per-channel counter, width $clog2(DEBOUNCE_CYCLES+1).
  - When s2 == level on an edge, the counter clears to 0.
  - When s2 != level, the counter increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, level <= s2 and the counter clears.
  - Latency: if E0 is the first edge sampling the new raw value and raw stays stable, level changes on edge E0+DEBOUNCE_CYCLES+1.
  - Any glitch shorter than DEBOUNCE_CYCLES samples clears the counter and leaves level unchanged.
- Edges: press and release are registered and updated on the same edge as level. Each is high for exactly the first cycle of the new level. press and release are never high together on one channel.
- Repeat FSM, per channel, states IDLE / HOLD / REPEAT, with a shared-width timer sized for max(REPEAT_DELAY, REPEAT_PERIOD):
  - IDLE: on press, go to HOLD with timer = 0.
  - HOLD: timer increments. At timer == REPEAT_DELAY-1, issue a repeat pulse, go to REPEAT, timer = 0.
  - REPEAT: timer increments. At timer == REPEAT_PERIOD-1, issue a repeat pulse, timer = 0.
  - From any state, release returns to IDLE and clears the timer. Release takes priority over a coincident repeat expiry, so no pulse is issued.
  - Channels with REPEAT_MASK bit = 0 never leave IDLE.
- strobe = press OR repeat pulse, registered and 1 cycle wide. Press at edge P gives strobes after edges P, P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_PERIOD, and so on.
- Channels are fully independent; simultaneous activity on several channels has no interaction.
- Reset mid-operation: all outputs drop immediately. A button still held when rst_n deasserts is treated as a new press, so press asserts DEBOUNCE_CYCLES+2 edges after release of reset.
- Counters never wrap: they saturate or clear as described.

Test Plan:
Sim parameters for all scenarios: N=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=2'b01, INVERT_MASK=2'b10.
- Clean press: raw_in[0] 0->1, first sampled at edge E0 -> level[0], press[0] and strobe[0] go high after edge E0+5. press is 1 cycle wide; level stays 1.
- Bounce: raw_in[0] toggles 1,0,1,0 every 2 cycles, then holds 1 -> exactly one press[0], at hold start +5 edges. No release pulses.
- Auto-repeat: hold ch0 with press at edge P -> strobe[0] after P, P+10, P+13, P+16. Release -> one release[0], no further strobes, FSM back to IDLE.
- Inverted, no repeat: raw_in[1] 1->0 and held 40 cycles -> one press[1] and one strobe[1]. No repeats. level[1]=1.
- Release/repeat collision: release ch0 so level falls on the edge of a repeat expiry -> release[0]=1, strobe[0]=0 on that edge.
- Async reset mid-hold: drop rst_n while ch0 is in REPEAT -> all outputs 0 immediately. Keep raw_in[0]=1, raise rst_n -> new press[0] 6 edges later.
